cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_PROD, 4, number of common-data-bus producers (functional units); legal range 2..8.
REQ-002 Parameter TAG_WIDTH, 6, width of a destination tag.
REQ-003 Parameter DATA_WIDTH, 32, width of a result word.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_PROD  per-producer broadcast request; producer holds req and payload stable until granted.
REQ-007 tag_in  input  N_PROD x TAG_WIDTH  per-producer destination tag.
REQ-008 data_in  input  N_PROD x DATA_WIDTH  per-producer result.
REQ-009 exception_in  input  N_PROD  per-producer exception flag.
REQ-010 grant  output  N_PROD  one-hot-or-zero grant, combinational, same cycle as req.
REQ-011 flush  input  1  pipeline flush from the reorder buffer; kills the pending broadcast.
REQ-012 cdb_ready  input  1  consumers (reservation stations, ROB) accept the current broadcast this cycle.
REQ-013 cdb_valid, cdb_tag, cdb_data, cdb_exception  output  1 / TAG_WIDTH / DATA_WIDTH / 1  registered broadcast.
REQ-014 perf_conflict_cnt  output  16  arbitration-conflict counter (Configuration section).

Function
REQ-015 Broadcast register "open" when cdb_valid==0 or cdb_ready==1.
REQ-016 grant SHALL be all-zero when flush==1, when the register is not open, or when req==0.
REQ-017 Otherwise exactly one grant bit SHALL assert: first requesting index at or after rr_ptr, searching upward with wrap from N_PROD-1 to 0.
REQ-018 On a grant to index i, rr_ptr SHALL become (i+1) mod N_PROD at the next edge; with no grant, rr_ptr SHALL hold.
REQ-019 On a grant to i, the register SHALL load tag_in[i], data_in[i], exception_in[i], and cdb_valid SHALL be 1 next cycle; latency grant->broadcast is exactly 1 cycle.
REQ-020 Register open and no grant (flush==0): cdb_valid SHALL go 0 next cycle.
REQ-021 Register not open (cdb_valid==1, cdb_ready==0): tag/data/exception/cdb_valid SHALL hold unchanged.
REQ-022 flush==1: cdb_valid SHALL be 0 next cycle regardless of cdb_ready or req; payload fields may hold.
REQ-023 A producer keeping req high after its grant SHALL be treated as a new request; back-to-back grants to one producer SHALL occur only when no other producer requests.
REQ-024 Fairness: a continuously requesting producer SHALL be granted within N_PROD open cycles.
REQ-025 Simultaneous cdb_ready==1 and new grant: old broadcast retires and new one loads in the same edge (full throughput, one broadcast per cycle).
REQ-026 cdb_data/cdb_tag/cdb_exception SHALL be don't-care when cdb_valid==0 but SHALL NOT be X after reset.

Reset
REQ-027 When rst_n==0 at an edge: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_exception=0, rr_ptr=0, perf_conflict_cnt=0.
REQ-028 During reset grant SHALL be all-zero; reset mid-broadcast SHALL discard the pending broadcast, and no grant issued in the reset cycle SHALL take effect.

Configuration
REQ-029 Macro CDB_ARB_PERF_EN.
REQ-030 Defined: perf_conflict_cnt SHALL increment by 1 on each edge where grant is nonzero and popcount(req)>=2, saturating at 16'hFFFF; cleared only by reset.
REQ-031 Not defined: perf_conflict_cnt SHALL be tied to 0 and no counter logic synthesised; all other behaviour identical.

Verification
REQ-032 Reset then req=4'b0000, cdb_ready=1 for 5 cycles -> grant=0, cdb_valid=0 throughout.
REQ-033 rr_ptr=0, req=4'b1111 held, cdb_ready=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; cdb_tag tracks granted tag_in one cycle later.
REQ-034 req=4'b0100 with tag_in[2]=6'h2A, data_in[2]=32'hDEADBEEF, exception_in[2]=1 -> grant=0100; next cycle cdb_valid=1, cdb_tag=6'h2A, cdb_data=32'hDEADBEEF, cdb_exception=1.
REQ-035 cdb_valid=1, cdb_ready=0 for 3 cycles with req=4'b0011 -> grant=0 and outputs frozen; cycle cdb_ready=1 -> grant issued per rr_ptr.
REQ-036 flush=1 while cdb_valid=1 and req=4'b1000 -> grant=0, next cycle cdb_valid=0, rr_ptr unchanged.
REQ-037 CDB_ARB_PERF_EN defined, req=4'b0110 for 10 open cycles -> perf_conflict_cnt=10; undefined -> stays 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and broadcast register for the common data bus.
//
// Each cycle, if the broadcast register is open (empty or being accepted) and no flush is
// pending, one requesting producer is granted combinationally. Its tag/data/exception are
// captured into the broadcast register at the next rising edge.
//
// Ports:
//   clk                  clock, rising edge
//   rst_n                synchronous active-low reset
//   req_i                per-producer broadcast request
//   tag_in_i             packed per-producer destination tags (producer i at [i*TAG_WIDTH +: TAG_WIDTH])
//   data_in_i            packed per-producer results (producer i at [i*DATA_WIDTH +: DATA_WIDTH])
//   exception_in_i       per-producer exception flag
//   grant_o              one-hot-or-zero grant, same cycle as req_i
//   flush_i              kills the pending broadcast
//   cdb_ready_i          consumers accept the current broadcast this cycle
//   cdb_valid_o / cdb_tag_o / cdb_data_o / cdb_exception_o   registered broadcast
//   perf_conflict_cnt_o  count of grants issued while two or more producers requested
//
// Build option: define CDB_ARB_PERF_EN to include the conflict counter; otherwise the
// counter output is tied to zero.

module cdb_arbiter #(
    parameter int unsigned N_PROD     = 4,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PROD-1:0]            req_i,
    input  logic [N_PROD*TAG_WIDTH-1:0]  tag_in_i,
    input  logic [N_PROD*DATA_WIDTH-1:0] data_in_i,
    input  logic [N_PROD-1:0]            exception_in_i,
    output logic [N_PROD-1:0]            grant_o,
    input  logic                         flush_i,
    input  logic                         cdb_ready_i,
    output logic                         cdb_valid_o,
    output logic [TAG_WIDTH-1:0]         cdb_tag_o,
    output logic [DATA_WIDTH-1:0]        cdb_data_o,
    output logic                         cdb_exception_o,
    output logic [15:0]                  perf_conflict_cnt_o
);

    localparam int unsigned PtrW = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    // One extra bit so rr_ptr + offset cannot overflow before the wrap correction.
    localparam int unsigned SumW = PtrW + 1;

    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic                  cdb_exc_q, cdb_exc_d;

    logic                  open;
    logic                  found;
    logic [N_PROD-1:0]     grant;
    logic [PtrW-1:0]       grant_idx;
    logic [PtrW-1:0]       ptr_nxt;
    logic [SumW-1:0]       sum;

    // Round-robin search starting at rr_ptr_q, wrapping at N_PROD-1.
    always_comb begin
        open      = !cdb_valid_q || cdb_ready_i;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        // Gating on rst_n keeps grant zero during reset.
        if (rst_n && !flush_i && open) begin
            for (int k = 0; k < N_PROD; k++) begin
                sum = {1'b0, rr_ptr_q} + SumW'(k);
                if (sum >= SumW'(N_PROD)) begin
                    sum = sum - SumW'(N_PROD);
                end
                if (!found && req_i[sum[PtrW-1:0]]) begin
                    found            = 1'b1;
                    grant_idx        = sum[PtrW-1:0];
                    grant[grant_idx] = 1'b1;
                end
            end
        end
    end

    assign grant_o = grant;
    assign ptr_nxt = (grant_idx == PtrW'(N_PROD - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_exc_d   = cdb_exc_q;
        if (flush_i) begin
            // Payload may hold; only validity is killed.
            cdb_valid_d = 1'b0;
        end else if (open) begin
            if (found) begin
                rr_ptr_d    = ptr_nxt;
                cdb_valid_d = 1'b1;
                cdb_tag_d   = tag_in_i[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
                cdb_data_d  = data_in_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                cdb_exc_d   = exception_in_i[grant_idx];
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_exc_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_exc_q   <= cdb_exc_d;
        end
    end

    assign cdb_valid_o     = cdb_valid_q;
    assign cdb_tag_o       = cdb_tag_q;
    assign cdb_data_o      = cdb_data_q;
    assign cdb_exception_o = cdb_exc_q;

`ifdef CDB_ARB_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Saturating count of contested grants.
    always_comb begin
        perf_d = perf_q;
        if (found && ($countones(req_i) >= 2) && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflict_cnt_o = perf_q;
`else
    assign perf_conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter (N_PROD=4, TAG_WIDTH=6, DATA_WIDTH=32).

module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] tag_in;
    logic [127:0] data_in;
    logic [3:0]  exc_in;
    logic [3:0]  grant;
    logic        flush;
    logic        cdb_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_exc;
    logic [15:0] perf_cnt;

    logic [5:0]  tg [4];
    logic [31:0] dt [4];

    int n_tests;
    int n_fail;

    cdb_arbiter #(
        .N_PROD    (4),
        .TAG_WIDTH (6),
        .DATA_WIDTH(32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_i              (req),
        .tag_in_i           (tag_in),
        .data_in_i          (data_in),
        .exception_in_i     (exc_in),
        .grant_o            (grant),
        .flush_i            (flush),
        .cdb_ready_i        (cdb_ready),
        .cdb_valid_o        (cdb_valid),
        .cdb_tag_o          (cdb_tag),
        .cdb_data_o         (cdb_data),
        .cdb_exception_o    (cdb_exc),
        .perf_conflict_cnt_o(perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        tag_in  = '0;
        data_in = '0;
        for (int i = 0; i < 4; i++) begin
            tag_in[i*6 +: 6]   = tg[i];
            data_in[i*32 +: 32] = dt[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; leave 1 time unit so outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g [5];
    logic [3:0] exp_alt;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        exc_in    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tg[i] = 6'(i + 1);
            dt[i] = 32'h1111_1111 * (i + 1);
        end
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        exp_g[4] = 4'b0001;

        // Reset: grant suppressed even with requests present.
        #1;
        check("grant_in_reset", 64'(grant), 64'h0);
        tick();
        tick();
        check("grant_in_reset2", 64'(grant), 64'h0);
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_tag", 64'(cdb_tag), 64'h0);
        check("rst_data", 64'(cdb_data), 64'h0);
        check("rst_exc", 64'(cdb_exc), 64'h0);
        check("rst_perf", 64'(perf_cnt), 64'h0);

        // Idle: no requests for 5 cycles.
        rst_n = 1'b1;
        req   = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("idle_grant", 64'(grant), 64'h0);
            tick();
            check("idle_valid", 64'(cdb_valid), 64'h0);
        end

        // All request: rotation 0,1,2,3,0; tag follows one cycle later.
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_grant", 64'(grant), 64'(exp_g[c]));
            tick();
            check("rr_valid", 64'(cdb_valid), 64'h1);
            check("rr_tag", 64'(cdb_tag), 64'(c % 4 + 1));
        end
        // rr_ptr now 1.

        // Single producer 2 with exception.
        req       = 4'b0100;
        tg[2]     = 6'h2A;
        dt[2]     = 32'hDEAD_BEEF;
        exc_in[2] = 1'b1;
        #1;
        check("single_grant", 64'(grant), 64'h4);
        tick();
        check("single_valid", 64'(cdb_valid), 64'h1);
        check("single_tag", 64'(cdb_tag), 64'h2A);
        check("single_data", 64'(cdb_data), 64'hDEAD_BEEF);
        check("single_exc", 64'(cdb_exc), 64'h1);
        // rr_ptr now 3.

        // Backpressure: register held, no grants.
        cdb_ready = 1'b0;
        req       = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_grant", 64'(grant), 64'h0);
            tick();
            check("bp_valid", 64'(cdb_valid), 64'h1);
            check("bp_tag", 64'(cdb_tag), 64'h2A);
            check("bp_data", 64'(cdb_data), 64'hDEAD_BEEF);
        end
        // Release: search from 3 wraps to 0.
        cdb_ready = 1'b1;
        #1;
        check("bp_release_grant", 64'(grant), 64'h1);
        tick();
        check("bp_release_tag", 64'(cdb_tag), 64'h01);
        check("bp_release_exc", 64'(cdb_exc), 64'h0);
        // rr_ptr now 1.

        // Flush while valid, with backpressure: kills broadcast, pointer untouched.
        flush     = 1'b1;
        cdb_ready = 1'b0;
        req       = 4'b1000;
        #1;
        check("flush_grant", 64'(grant), 64'h0);
        tick();
        check("flush_valid", 64'(cdb_valid), 64'h0);
        flush     = 1'b0;
        cdb_ready = 1'b1;
        req       = 4'b1111;
        #1;
        check("post_flush_grant", 64'(grant), 64'h2);
        tick();
        check("post_flush_tag", 64'(cdb_tag), 64'h02);

        // Reset mid-broadcast discards it; grant issued during reset has no effect.
        rst_n = 1'b0;
        #1;
        check("midrst_grant", 64'(grant), 64'h0);
        tick();
        check("midrst_valid", 64'(cdb_valid), 64'h0);
        check("midrst_tag", 64'(cdb_tag), 64'h0);
        rst_n = 1'b1;

        // Two contenders for 10 open cycles; rotation 1,2,1,2...
        req = 4'b0110;
        for (int c = 0; c < 10; c++) begin
            exp_alt = (c % 2 == 0) ? 4'b0010 : 4'b0100;
            #1;
            check("pair_grant", 64'(grant), 64'(exp_alt));
            tick();
        end
`ifdef CDB_ARB_PERF_EN
        check("perf_cnt", 64'(perf_cnt), 64'd10);
`else
        check("perf_cnt", 64'(perf_cnt), 64'd0);
`endif

        // Open with no request: valid drops.
        req = 4'b0000;
        tick();
        check("drain_valid", 64'(cdb_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
